// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - handshake bundle between fetch, instruction memory, redirect source and decode
// Signals:
//   imem_req_valid/addr/ready   fetch -> imem word request handshake
//   imem_resp_valid/data        imem -> fetch in-order response
//   redirect_valid/pc           decode/execute -> fetch flush and restart
//   out_valid/pc/instr/ready    fetch -> decode instruction handshake
// master: the fetch unit; slave: its environment.
interface instr_fetch_unit_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [ILEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_instr;
  logic            out_ready;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - RISC-V fetch stage: PC, credited imem requests, response FIFO, redirect flush
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    instr_fetch_unit_if.master (imem request/response, redirect, decode output)
module instr_fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic                clock,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [PW-1:0] ptr_t;

  logic [XLEN-1:0] pc_q, pc_d;
  cnt_t            outst_q, outst_d;
  cnt_t            drop_q, drop_d;
  cnt_t            fcnt_q, fcnt_d;
  ptr_t            f_rd_q, f_rd_d, f_wr_q, f_wr_d;
  ptr_t            p_rd_q, p_rd_d, p_wr_q, p_wr_d;
  logic [XLEN-1:0] fifo_pc_q [DEPTH];
  logic [XLEN-1:0] fifo_pc_d [DEPTH];
  logic [ILEN-1:0] fifo_instr_q [DEPTH];
  logic [ILEN-1:0] fifo_instr_d [DEPTH];
  // Address of every outstanding request, so each response gets its own PC.
  logic [XLEN-1:0] pcq_q [DEPTH];
  logic [XLEN-1:0] pcq_d [DEPTH];

  logic credit, req_valid, fire, resp, keep, pop, out_valid;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    credit    = ({1'b0, outst_q} + {1'b0, fcnt_q}) < (CW + 1)'(DEPTH);
    req_valid = !reset && !bus.redirect_valid && credit;
    fire      = req_valid && bus.imem_req_ready;
    // A response with nothing outstanding is a protocol violation and is ignored.
    resp      = bus.imem_resp_valid && (outst_q != '0);
    keep      = resp && (drop_q == '0) && !bus.redirect_valid;
    out_valid = (fcnt_q != '0);
    pop       = out_valid && bus.out_ready && !bus.redirect_valid;
  end

  always_comb begin
    pc_d         = pc_q;
    outst_d      = outst_q + cnt_t'(fire) - cnt_t'(resp);
    drop_d       = drop_q;
    fcnt_d       = fcnt_q + cnt_t'(keep) - cnt_t'(pop);
    f_rd_d       = f_rd_q;
    f_wr_d       = f_wr_q;
    p_rd_d       = p_rd_q;
    p_wr_d       = p_wr_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    pcq_d        = pcq_q;

    if (fire) begin
      pcq_d[p_wr_q] = pc_q;
      p_wr_d        = ptr_inc(p_wr_q);
      pc_d          = pc_q + XLEN'(4);
    end
    if (resp) begin
      p_rd_d = ptr_inc(p_rd_q);
      if (drop_q != '0) drop_d = drop_q - 1'b1;
    end
    if (keep) begin
      fifo_pc_d[f_wr_q]    = pcq_q[p_rd_q];
      fifo_instr_d[f_wr_q] = bus.imem_resp_data;
      f_wr_d               = ptr_inc(f_wr_q);
    end
    if (pop) f_rd_d = ptr_inc(f_rd_q);

    if (bus.redirect_valid) begin
      pc_d   = bus.redirect_pc & ~XLEN'(3);
      // Everything still outstanding after this edge belongs to the old path.
      drop_d = outst_q - cnt_t'(resp);
      fcnt_d = '0;
      f_rd_d = '0;
      f_wr_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
      fcnt_q  <= '0;
      f_rd_q  <= '0;
      f_wr_q  <= '0;
      p_rd_q  <= '0;
      p_wr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
        pcq_q[i]        <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      outst_q      <= outst_d;
      drop_q       <= drop_d;
      fcnt_q       <= fcnt_d;
      f_rd_q       <= f_rd_d;
      f_wr_q       <= f_wr_d;
      p_rd_q       <= p_rd_d;
      p_wr_q       <= p_wr_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
      pcq_q        <= pcq_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.out_valid      = out_valid;
  assign bus.out_pc         = fifo_pc_q[f_rd_q];
  assign bus.out_instr      = fifo_instr_q[f_rd_q];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit against a queue-based fetch model
module tb_instr_fetch_unit;
  localparam int          XLEN   = 64;
  localparam int          ILEN   = 32;
  localparam int          DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h1000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instr_fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

  instr_fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {logic [63:0] addr; int epoch; int due;} req_t;
  typedef struct {logic [63:0] pc; logic [31:0] instr;} ent_t;

  req_t        mem_q[$];   // accepted requests awaiting their response
  ent_t        buf_q[$];   // instructions decode should currently see, oldest first
  logic [63:0] m_pc;
  int          epoch, cyc, lat, last_due;
  int          checks, errors;
  bit          redir_done;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs, advance the model.
  task automatic step(input bit rd, input logic [63:0] rpc, input bit rd_need_resp,
                      input bit ordy, input bit rrdy);
    bit   resp, exp_req, fire, pop, do_rd;
    int   due;
    req_t r;
    resp  = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    do_rd = rd && (!rd_need_resp || (resp && buf_q.size() > 0));
    bus.imem_resp_valid = resp;
    bus.imem_resp_data  = resp ? mem_word(mem_q[0].addr) : 32'h0;
    bus.redirect_valid  = do_rd;
    bus.redirect_pc     = rpc;
    bus.out_ready       = ordy;
    bus.imem_req_ready  = rrdy;
    #1;
    exp_req = !do_rd && (mem_q.size() + buf_q.size() < DEPTH);
    chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_req));
    if (exp_req) chk("req_addr", bus.imem_req_addr, m_pc);
    chk("out_valid", 64'(bus.out_valid), 64'(buf_q.size() > 0));
    if (buf_q.size() > 0) begin
      chk("out_pc", bus.out_pc, buf_q[0].pc);
      chk("out_instr", 64'(bus.out_instr), 64'(buf_q[0].instr));
    end
    fire = exp_req && rrdy;
    pop  = (buf_q.size() > 0) && ordy && !do_rd;
    if (pop) void'(buf_q.pop_front());
    if (resp) begin
      r = mem_q.pop_front();
      if (!do_rd && r.epoch == epoch) buf_q.push_back('{r.addr, mem_word(r.addr)});
    end
    if (fire) begin
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mem_q.push_back('{m_pc, epoch, due});
      last_due = due;
      m_pc += 64'd4;
    end
    if (do_rd) begin
      buf_q.delete();
      epoch++;
      m_pc = {rpc[63:2], 2'b00};
    end
    redir_done = do_rd;
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; epoch = 0; lat = 1; last_due = -1;
    m_pc = RST_PC; redir_done = 1'b0;
    reset = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b0;
    #1;
    chk("reset_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("reset_req_addr", bus.imem_req_addr, RST_PC);
    chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
    chk("reset_out_pc", bus.out_pc, 64'd0);
    chk("reset_out_instr", 64'(bus.out_instr), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Sequential fetch, 1-cycle memory, decode always ready.
    lat = 1;
    repeat (12) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Decode backpressure: buffer fills and requests stop.
    repeat (10) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("bp_req_blocked", 64'(bus.imem_req_valid), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    repeat (8) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Memory stall: address held, PC frozen.
    repeat (5) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    for (int i = 0; i < 20 && mem_q.size() != 2; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("two_in_flight", 64'(mem_q.size()), 64'd2);
    step(1'b1, 64'h2002, 1'b0, 1'b1, 1'b1);
    chk("redir_addr", bus.imem_req_addr, 64'h2000);
    repeat (14) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Redirect in the same cycle as a response and a pop.
    lat = 1;
    redir_done = 1'b0;
    for (int i = 0; i < 30 && !redir_done; i++) step(1'b1, 64'h3000, 1'b1, 1'b1, 1'b1);
    chk("coincident_found", 64'(redir_done), 64'd1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    repeat (8) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Randomised traffic with occasional redirects.
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      step(($urandom_range(0, 19) == 0), {$urandom, $urandom}, 1'b0,
           bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0));
    end

    // PC wrap through the top of the address space.
    lat = 1;
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    repeat (12) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a cycle.
    repeat (3) step(1'b0, '0, 1'b0, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 64'(bus.out_valid), 64'd0);
    chk("async_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("async_req_addr", bus.imem_req_addr, RST_PC);
    bus.imem_resp_valid = 1'b0;
    mem_q.delete(); buf_q.delete();
    m_pc = RST_PC; epoch++; last_due = -1;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) step(1'b0, '0, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
